// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: shift-register scoreboard of in-flight destinations driving
// EX forwarding selects, load-use stalls, bubble insertion and stall/flush counters.
module hazard_scoreboard #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [REG_W-1:0]        id_rs,
  input  logic                    id_rs_used,
  input  logic [REG_W-1:0]        id_rt,
  input  logic                    id_rt_used,
  input  logic [REG_W-1:0]        id_rd,
  input  logic                    id_we,
  input  logic                    id_load,
  input  logic                    flush,
  output logic                    stall,
  output logic [SEL_W-1:0]        fwd_rs_sel,
  output logic [SEL_W-1:0]        fwd_rt_sel,
  output logic [STAGES*REG_W-1:0] stage_rd,
  output logic [STAGES-1:0]       stage_we,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  logic [REG_W-1:0]  rd_q [STAGES];
  logic [STAGES-1:0] we_q;
  logic [STAGES-1:0] load_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic [REG_W-1:0]  rd0_d;
  logic              we0_d;
  logic              load0_d;

  logic              rs_hit, rt_hit;
  logic              rs_ld, rt_ld;
  int unsigned       rs_k, rt_k;
  logic              hazard_rs, hazard_rt;
  logic              stall_int;

  // Ascending search with a found flag so the youngest match shadows older ones.
  always_comb begin
    rs_hit = 1'b0;
    rs_ld  = 1'b0;
    rs_k   = 0;
    rt_hit = 1'b0;
    rt_ld  = 1'b0;
    rt_k   = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (!rs_hit && id_rs_used && (id_rs != '0) && we_q[k] && (rd_q[k] == id_rs)) begin
        rs_hit = 1'b1;
        rs_ld  = load_q[k];
        rs_k   = k;
      end
      if (!rt_hit && id_rt_used && (id_rt != '0) && we_q[k] && (rd_q[k] == id_rt)) begin
        rt_hit = 1'b1;
        rt_ld  = load_q[k];
        rt_k   = k;
      end
    end
  end

  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    if (FWD_EN) begin
      hazard_rs = rs_hit && rs_ld && (rs_k < LOAD_STAGE);
      hazard_rt = rt_hit && rt_ld && (rt_k < LOAD_STAGE);
    end else begin
      // The oldest entry writes the regfile in the first half-cycle, so it never hazards.
      hazard_rs = rs_hit && (rs_k < STAGES - 1);
      hazard_rt = rt_hit && (rt_k < STAGES - 1);
    end
  end

  assign stall_int  = id_valid && !flush && (hazard_rs || hazard_rt);
  assign stall      = stall_int;
  assign fwd_rs_sel = (FWD_EN && rs_hit) ? SEL_W'(rs_k + 1) : '0;
  assign fwd_rt_sel = (FWD_EN && rt_hit) ? SEL_W'(rt_k + 1) : '0;

  always_comb begin
    rd0_d   = '0;
    we0_d   = 1'b0;
    load0_d = 1'b0;
    if (id_valid && !flush && !stall_int) begin
      rd0_d   = id_rd;
      we0_d   = id_we && (id_rd != '0);
      load0_d = id_load;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < STAGES; k++) rd_q[k] <= '0;
      we_q        <= '0;
      load_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        rd_q[k]   <= rd_q[k-1];
        we_q[k]   <= we_q[k-1];
        load_q[k] <= load_q[k-1];
      end
      rd_q[0]   <= rd0_d;
      we_q[0]   <= we0_d;
      load_q[0] <= load0_d;
      if (stall_int && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))     flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    stage_rd = '0;
    for (int unsigned k = 0; k < STAGES; k++) stage_rd[k*REG_W +: REG_W] = rd_q[k];
  end

  assign stage_we  = we_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: forwarding and non-forwarding instances share stimulus and
// are checked against an age-indexed history model of in-flight instructions.
module tb_hazard_scoreboard;
  localparam int RW = 5;
  localparam int ST = 3;
  localparam int LS = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic id_we = 1'b0, id_load = 1'b0, flush = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;

  logic        stall_a, stall_b;
  logic [1:0]  rs_a, rt_a, rs_b, rt_b;
  logic [14:0] srd_a, srd_b;
  logic [2:0]  swe_a, swe_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  always #5 clock = ~clock;

  hazard_scoreboard #(.REG_W(5), .STAGES(3), .LOAD_STAGE(1), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .flush(flush),
    .stall(stall_a), .fwd_rs_sel(rs_a), .fwd_rt_sel(rt_a),
    .stage_rd(srd_a), .stage_we(swe_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

  hazard_scoreboard #(.REG_W(5), .STAGES(3), .LOAD_STAGE(1), .FWD_EN(1'b0), .CNT_W(4)) u_nofwd (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .flush(flush),
    .stall(stall_b), .fwd_rs_sel(rs_b), .fwd_rt_sel(rt_b),
    .stage_rd(srd_b), .stage_we(swe_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

  typedef struct { int rd; bit we; bit ld; } ent_t;
  ent_t        hist [2][ST];   // hist[d][age]: instruction issued age+1 cycles ago
  int unsigned scnt [2];
  int unsigned fcnt [2];
  int unsigned cmax [2] = '{65535, 15};
  bit          fwd  [2] = '{1'b1, 1'b0};
  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < ST; k++) hist[d][k] = '{0, 1'b0, 1'b0};
      scnt[d] = 0;
      fcnt[d] = 0;
    end
  endfunction

  function automatic int youngest(input int d, input int s, input bit used);
    int age = -1;
    if (used && s != 0)
      for (int k = ST - 1; k >= 0; k--)
        if (hist[d][k].we && hist[d][k].rd == s) age = k;
    return age;
  endfunction

  function automatic bit hz(input int d, input int age);
    if (age < 0) return 1'b0;
    if (fwd[d]) return hist[d][age].ld && (age < LS);
    return age < ST - 1;
  endfunction

  function automatic void model_eval(input int d, output bit st, output int srs, output int srt);
    int a = youngest(d, int'(id_rs), id_rs_used);
    int b = youngest(d, int'(id_rt), id_rt_used);
    st  = id_valid && !flush && (hz(d, a) || hz(d, b));
    srs = (fwd[d] && a >= 0) ? a + 1 : 0;
    srt = (fwd[d] && b >= 0) ? b + 1 : 0;
  endfunction

  function automatic void model_edge(input int d);
    bit st;
    int a, b;
    model_eval(d, st, a, b);
    if (st && scnt[d] < cmax[d]) scnt[d]++;
    if (flush && fcnt[d] < cmax[d]) fcnt[d]++;
    for (int k = ST - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
    if (flush || st || !id_valid) hist[d][0] = '{0, 1'b0, 1'b0};
    else hist[d][0] = '{int'(id_rd), id_we && (id_rd != 0), id_load};
  endfunction

  task automatic check_now();
    bit st;
    int a, b;
    logic o_st;
    logic [1:0] o_rs, o_rt;
    logic [14:0] o_rd;
    logic [2:0] o_we;
    logic [15:0] o_sc, o_fc;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        o_st = stall_a; o_rs = rs_a; o_rt = rt_a; o_rd = srd_a; o_we = swe_a; o_sc = sc_a; o_fc = fc_a;
      end else begin
        o_st = stall_b; o_rs = rs_b; o_rt = rt_b; o_rd = srd_b; o_we = swe_b;
        o_sc = {12'h0, sc_b}; o_fc = {12'h0, fc_b};
      end
      model_eval(d, st, a, b);
      chk($sformatf("stall[%0d]", d), 32'(o_st), 32'(st));
      if (id_valid && !st) begin
        chk($sformatf("rs_sel[%0d]", d), 32'(o_rs), 32'(a));
        chk($sformatf("rt_sel[%0d]", d), 32'(o_rt), 32'(b));
      end
      for (int k = 0; k < ST; k++) begin
        chk($sformatf("we[%0d][%0d]", d, k), 32'(o_we[k]), 32'(hist[d][k].we));
        if (hist[d][k].we) chk($sformatf("rd[%0d][%0d]", d, k), 32'(o_rd[k*RW +: RW]), 32'(hist[d][k].rd));
      end
      chk($sformatf("stall_cnt[%0d]", d), 32'(o_sc), 32'(scnt[d]));
      chk($sformatf("flush_cnt[%0d]", d), 32'(o_fc), 32'(fcnt[d]));
    end
  endtask

  // Drives one ID-stage instruction and returns at the following falling edge.
  task automatic issue(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input int rd, input bit we, input bit ld, input bit fl, input bit do_chk);
    id_valid = v; id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt); id_rt_used = rtu;
    id_rd = 5'(rd); id_we = we; id_load = ld; flush = fl;
    @(negedge clock);
    if (do_chk) check_now();
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  initial begin
    int unsigned base;
    bit hold, st, rv, rsu, rtu, we, ld, fl;
    int a, b, rs, rt, rd;

    model_reset();
    #12;
    chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_we", 32'(swe_a), 32'd0);
    chk("rst_rd", 32'(srd_a), 32'd0);
    chk("rst_cnt", 32'({sc_a, fc_a}), 32'd0);
    reset = 1'b1;
    tick();

    // Distance from a producer to its consumer selects EX/MEM/WB/regfile.
    for (int n = 0; n < 4; n++) begin
      issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 1); tick();
      for (int j = 0; j < n; j++) begin issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick(); end
      issue(1, 3, 1, 5, 1, 4, 1, 0, 0, 1);
      chk($sformatf("gap%0d_sel", n), 32'(rs_a), (n < 3) ? 32'(n + 1) : 32'd0);
      chk($sformatf("gap%0d_stall", n), 32'(stall_a), 32'd0);
      tick();
    end

    // Load-use: one stall, then both sources from MEM.
    base = scnt[0];
    issue(1, 1, 1, 0, 0, 3, 1, 1, 0, 1); tick();
    issue(1, 3, 1, 3, 1, 4, 1, 0, 0, 1);
    chk("lu_stall", 32'(stall_a), 32'd1);
    tick();
    issue(1, 3, 1, 3, 1, 4, 1, 0, 0, 1);
    chk("lu_stall2", 32'(stall_a), 32'd0);
    chk("lu_rs", 32'(rs_a), 32'd2);
    chk("lu_rt", 32'(rt_a), 32'd2);
    chk("lu_bubble", 32'(swe_a[0]), 32'd0);
    tick();
    chk("lu_cnt", 32'(sc_a), 32'(base + 1));

    // Writes to $0 never register and never match.
    issue(1, 0, 0, 0, 0, 0, 1, 0, 0, 1); tick();
    issue(1, 0, 1, 0, 1, 5, 1, 0, 0, 1);
    chk("r0_rs", 32'(rs_a), 32'd0);
    chk("r0_rt", 32'(rt_a), 32'd0);
    chk("r0_stall", 32'(stall_a), 32'd0);
    chk("r0_we", 32'(swe_a[0]), 32'd0);
    tick();

    // Flush beats a load-use stall.
    issue(1, 1, 1, 0, 0, 3, 1, 1, 0, 1); tick();
    base = fcnt[0];
    issue(1, 3, 1, 3, 1, 4, 1, 0, 1, 1);
    chk("fl_stall", 32'(stall_a), 32'd0);
    tick();
    chk("fl_bubble", 32'(swe_a[0]), 32'd0);
    chk("fl_cnt", 32'(fc_a), 32'(base + 1));

    // Non-forwarding instance: immediate RAW stalls STAGES-1 cycles.
    for (int j = 0; j < 3; j++) begin issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick(); end
    issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 1); tick();
    base = scnt[1];
    for (int j = 0; j < 3; j++) begin
      issue(1, 3, 1, 6, 1, 4, 1, 0, 0, 1);
      chk($sformatf("nf_stall%0d", j), 32'(stall_b), (j < 2) ? 32'd1 : 32'd0);
      chk($sformatf("nf_sel%0d", j), 32'({rs_b, rt_b}), 32'd0);
      tick();
    end
    chk("nf_cnt", 32'(sc_b), (base + 2 > 15) ? 32'd15 : 32'(base + 2));

    // Random traffic; a stalled instruction is re-presented as the pipeline would.
    hold = 1'b0;
    rv = 0; rs = 0; rsu = 0; rt = 0; rtu = 0; rd = 0; we = 0; ld = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        rv  = $urandom_range(0, 9) != 0;
        rs  = $urandom_range(0, 7);  rsu = $urandom_range(0, 1) != 0;
        rt  = $urandom_range(0, 7);  rtu = $urandom_range(0, 1) != 0;
        rd  = $urandom_range(0, 7);  we  = $urandom_range(0, 3) != 0;
        ld  = we && ($urandom_range(0, 2) == 0);
      end
      fl = $urandom_range(0, 9) == 0;
      issue(rv, rs, rsu, rt, rtu, rd, we, ld, fl, 1);
      model_eval(0, st, a, b);
      hold = st;
      tick();
    end
    chk("nf_sat", 32'(sc_b), 32'hF);

    // Hold flush long enough to saturate the 16-bit counter.
    for (int i = 0; i < 65541; i++) begin
      issue(1, 1, 1, 2, 1, 3, 1, 0, 1, 0);
      tick();
    end
    chk("fl_sat_a", 32'(fc_a), 32'hFFFF);
    chk("fl_sat_b", 32'(fc_b), 32'hF);
    issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 1); tick();

    // Asynchronous reset while a load-use stall is active.
    issue(1, 1, 1, 0, 0, 3, 1, 1, 0, 1); tick();
    issue(1, 3, 1, 3, 1, 4, 1, 0, 0, 1);
    chk("ar_pre_stall", 32'(stall_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_stall", 32'(stall_a), 32'd0);
    chk("ar_we", 32'({swe_a, swe_b}), 32'd0);
    chk("ar_cnt_a", 32'({sc_a, fc_a}), 32'd0);
    chk("ar_cnt_b", 32'({sc_b, fc_b}), 32'd0);
    model_reset();
    id_valid = 1'b0;
    reset = 1'b1;
    tick();
    issue(1, 3, 1, 3, 1, 4, 1, 0, 0, 1); tick();
    issue(1, 4, 1, 0, 0, 5, 1, 0, 0, 1);
    chk("post_rs", 32'(rs_a), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
